// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: bit-serial shift sequencer for the MIPS shift path.
// Accepts a shift request, selects the amount source (shamt or rs),
// loads the operand and shifts it one bit per cycle, then pulses done.
//
// Build option: define SHIFT_ROTATE_EN to make op=11 a rotate right.
// Without it, op=11 behaves as SRL and no rotate feedback is built.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; op and shift_src captured on acceptance
// LOAD   | operand and selected amount loaded; zero amount skips SHIFT
// SHIFT  | one bit shifted and count decremented per cycle
// DONE   | done pulsed for one cycle; result valid and then held
//
// DATA_W must equal 2**AMT_W so that every amount 0..DATA_W-1 is reachable.

module shift_seq_ctrl #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic              shift_src,
    input  logic [AMT_W-1:0]  shamt,
    input  logic [DATA_W-1:0] rs_amt,
    input  logic [DATA_W-1:0] data_in,
    output logic              sel_shift_src,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_SHIFT = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam logic [AMT_W-1:0] CNT_ZERO = '0;
    localparam logic [AMT_W-1:0] CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic                src_q, src_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [AMT_W-1:0]    count_q, count_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [AMT_W-1:0]    amt_sel;
    logic [DATA_W-1:0]   shifted;

    // Only the low AMT_W bits of the register amount are meaningful.
    logic                unused_rs_hi;
    assign unused_rs_hi = ^rs_amt[DATA_W-1:AMT_W];

    // Amount mux follows the captured source select, which is already
    // stable by the time LOAD samples through it.
    always_comb begin
        amt_sel = src_q ? rs_amt[AMT_W-1:0] : shamt;
    end

    // One-bit step of the current operation applied to the result register.
    always_comb begin
        shifted = {1'b0, result_q[DATA_W-1:1]};
        case (op_q)
            OP_SLL: shifted = {result_q[DATA_W-2:0], 1'b0};
            OP_SRL: shifted = {1'b0, result_q[DATA_W-1:1]};
            OP_SRA: shifted = {result_q[DATA_W-1], result_q[DATA_W-1:1]};
            OP_ROR: begin
`ifdef SHIFT_ROTATE_EN
                shifted = {result_q[0], result_q[DATA_W-1:1]};
`else
                shifted = {1'b0, result_q[DATA_W-1:1]};
`endif
            end
            default: shifted = {1'b0, result_q[DATA_W-1:1]};
        endcase
    end

    // Next-state and next-register values; outputs are registered from these.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        src_d    = src_q;
        result_d = result_q;
        count_d  = count_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    src_d   = shift_src;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                result_d = data_in;
                count_d  = amt_sel;
                state_d  = (amt_sel != CNT_ZERO) ? S_SHIFT : S_DONE;
            end
            S_SHIFT: begin
                result_d = shifted;
                count_d  = count_q - CNT_ONE;
                if (count_q == CNT_ONE) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q     <= OP_SLL;
            src_q    <= 1'b0;
            result_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            op_q     <= op_d;
            src_q    <= src_d;
            result_q <= result_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sel_shift_src = src_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign result        = result_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Testbench for shift_seq_ctrl: directed cases plus random operations
// checked against an arithmetic model of the shift operations and timing.

module tb_shift_seq_ctrl;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic        shift_src;
    logic [4:0]  shamt;
    logic [31:0] rs_amt;
    logic [31:0] data_in;
    logic        sel_shift_src;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    shift_seq_ctrl #(.DATA_W(32), .AMT_W(5)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .op            (op),
        .shift_src     (shift_src),
        .shamt         (shamt),
        .rs_amt        (rs_amt),
        .data_in       (data_in),
        .sel_shift_src (sel_shift_src),
        .busy          (busy),
        .done          (done),
        .result        (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d, input int n);
        logic [31:0] r;
        case (o)
            2'b00:   r = d << n;
            2'b01:   r = d >> n;
            2'b10:   r = $unsigned($signed(d) >>> n);
            default: begin
`ifdef SHIFT_ROTATE_EN
                r = (n == 0) ? d : ((d >> n) | (d << (32 - n)));
`else
                r = d >> n;
`endif
            end
        endcase
        return r;
    endfunction

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and follow it cycle by cycle up to the cycle after DONE.
    task automatic do_op(input logic [1:0] o, input logic s, input logic [4:0] sh,
                         input logic [31:0] ra, input logic [31:0] d,
                         input bit hold, input logic [31:0] exp_res, input string tag);
        int n;
        int done_cyc;
        n = s ? int'(ra[4:0]) : int'(sh);
        step();
        start = 1'b1; op = o; shift_src = s; shamt = sh; rs_amt = ra; data_in = d;
        step();                                   // cycle 1 (LOAD)
        if (!hold) start = 1'b0;
        check({tag, ".sel"},  {31'b0, sel_shift_src}, {31'b0, s});
        check({tag, ".busy1"}, {31'b0, busy}, 32'd1);
        done_cyc = -1;
        for (int k = 2; k <= 40; k++) begin
            step();
            if (done) begin
                done_cyc = k;
                break;
            end
            check({tag, ".busy_mid"}, {31'b0, busy}, 32'd1);
        end
        check({tag, ".done_cyc"}, done_cyc, n + 2);
        check({tag, ".result"}, result, exp_res);
        check({tag, ".busy_done"}, {31'b0, busy}, 32'd1);
        step();                                   // cycle N+3 (IDLE)
        check({tag, ".busy_end"}, {31'b0, busy}, 32'd0);
        check({tag, ".done_end"}, {31'b0, done}, 32'd0);
        check({tag, ".hold"}, result, exp_res);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic        r_src;
        logic [4:0]  r_sh;
        logic [31:0] r_ra;
        logic [31:0] r_d;
        int          n;
        bit          seen;

        reset_n = 1'b0; start = 1'b0; op = 2'b00; shift_src = 1'b0;
        shamt = '0; rs_amt = '0; data_in = '0;
        repeat (3) step();
        check("rst.busy",   {31'b0, busy}, 32'd0);
        check("rst.done",   {31'b0, done}, 32'd0);
        check("rst.sel",    {31'b0, sel_shift_src}, 32'd0);
        check("rst.result", result, 32'd0);
        reset_n = 1'b1;
        step();

        do_op(2'b00, 1'b0, 5'd4,  32'h0,        32'h00000001, 1'b0, 32'h00000010, "sll4");
        do_op(2'b10, 1'b1, 5'd0,  32'hFFFFFF23, 32'h80000000, 1'b0, 32'hF0000000, "sra3");
        do_op(2'b01, 1'b0, 5'd0,  32'h0,        32'hDEADBEEF, 1'b0, 32'hDEADBEEF, "srl0");
        do_op(2'b01, 1'b0, 5'd31, 32'h0,        32'hDEADBEEF, 1'b0, 32'h00000001, "srl31");
`ifdef SHIFT_ROTATE_EN
        do_op(2'b11, 1'b0, 5'd1,  32'h0,        32'h00000003, 1'b0, 32'h80000001, "ror1");
`else
        do_op(2'b11, 1'b0, 5'd1,  32'h0,        32'h00000003, 1'b0, 32'h00000001, "ror1");
`endif
        do_op(2'b10, 1'b0, 5'd31, 32'h0,        32'h40000000, 1'b0, 32'h00000000, "sra31pos");

        // start held high: DONE-cycle start ignored, accepted again in cycle N+3
        do_op(2'b00, 1'b0, 5'd2, 32'h0, 32'h00000005, 1'b1, 32'h00000014, "hold");
        step();
        check("hold.reaccept", {31'b0, busy}, 32'd1);
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("hold.second_done", {31'b0, seen}, 32'd1);
        check("hold.second_result", result, 32'h00000014);
        step();

        // reset asserted in cycle 3 of an SLL by 8
        step();
        start = 1'b1; op = 2'b00; shift_src = 1'b0; shamt = 5'd8; data_in = 32'h0000_00FF;
        step();                                   // cycle 1
        start = 1'b0;
        step();                                   // cycle 2
        step();                                   // cycle 3
        reset_n = 1'b0;
        step();                                   // cycle 4
        reset_n = 1'b1;
        check("abort.busy",   {31'b0, busy}, 32'd0);
        check("abort.done",   {31'b0, done}, 32'd0);
        check("abort.sel",    {31'b0, sel_shift_src}, 32'd0);
        check("abort.result", result, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (done || busy) seen = 1'b1;
        end
        check("abort.no_done", {31'b0, seen}, 32'd0);

        // random operations
        for (int i = 0; i < 24; i++) begin
            r_op  = 2'($urandom_range(0, 3));
            r_src = 1'($urandom_range(0, 1));
            r_sh  = 5'($urandom_range(0, 31));
            r_ra  = $urandom;
            r_d   = $urandom;
            n     = r_src ? int'(r_ra[4:0]) : int'(r_sh);
            do_op(r_op, r_src, r_sh, r_ra, r_d, 1'b0, model(r_op, r_d, n), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencer for the MIPS shift path. Accepts a shift request from the main control unit, drives the shift-source mux select (shamt field vs. register amount), loads the operand, and performs the shift one bit per cycle. Signals completion with a one-cycle `done` pulse. Sits between the control FSM and the register-file/ALU output bus and replaces a combinational barrel shifter.

## Interface
Parameters:
- `DATA_W`, 32: operand/result width.
- `AMT_W`, 5: shift-amount width; must satisfy 2^AMT_W == DATA_W.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `start`  in  1: request; sampled only in IDLE.
- `op`  in  2: 00 SLL, 01 SRL, 10 SRA, 11 ROR (see Configuration).
- `shift_src`  in  1: 0 = amount from `shamt`, 1 = amount from `rs_amt[AMT_W-1:0]`.
- `shamt`  in  AMT_W: instruction shamt field.
- `rs_amt`  in  DATA_W: register value supplying the amount; upper bits ignored.
- `data_in`  in  DATA_W: operand (rt).
- `sel_shift_src`  out  1: drives the shift-source mux select.
- `busy`  out  1: high in LOAD, SHIFT and DONE.
- `done`  out  1: one-cycle completion pulse.
- `result`  out  DATA_W: shifted value.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE: `start`=1 captures `op` and `shift_src` into internal registers; `sel_shift_src` <= `shift_src`; next state LOAD. `start`=0 stays in IDLE.
- LOAD: `result` <= `data_in`; `count` <= selected amount (`shamt` or `rs_amt[AMT_W-1:0]`, chosen by the captured `shift_src`). Next state SHIFT if the amount != 0, else DONE.
- SHIFT: each cycle shifts `result` by one bit and decrements `count`:
  - SLL: zero fill at the LSB.
  - SRL: zero fill at the MSB.
  - SRA: MSB replicated.
  - ROR: LSB moves to the MSB.
  - When the cycle's decrement takes `count` from 1 to 0, next state is DONE.
- DONE: `done`=1 for exactly this cycle; next state IDLE.
- `result` holds its value from DONE until the next LOAD.
- `sel_shift_src` holds until the next accepted `start`.
- `start` outside IDLE is ignored and is not queued.
- `data_in`, `shamt` and `rs_amt` must be stable in the LOAD cycle. Other cycles are don't-care.
- The amount is taken modulo 2^AMT_W. Only bits [AMT_W-1:0] are used; max shift is 31.
- `count` is AMT_W bits wide and never wraps. Zero is checked in LOAD before any decrement.
- Reset (`reset_n`=0 at a rising edge), in any state including mid-SHIFT:
  - state returns to IDLE.
  - `result`, `count`, `sel_shift_src`, `busy` and `done` all go to 0.
  - no `done` pulse is produced for the aborted operation.

## Timing
- Cycle 0: the IDLE cycle in which `start`=1 is sampled.
- Cycle 1 is LOAD. Cycles 2..N+1 are SHIFT, where N = amount. Cycle N+2 is DONE.
- `done` is high in cycle N+2 (N=0: cycle 2; N=31: cycle 33). `result` is valid in the same cycle.
- Earliest next accepted `start` is cycle N+3.
- `busy` rises in cycle 1 and falls in cycle N+3.
- `sel_shift_src` is valid from cycle 1, i.e. before LOAD samples through the mux.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro: `SHIFT_ROTATE_EN`.
- Defined: `op`=11 performs a rotate right (ROR).
- Undefined: `op`=11 behaves exactly as SRL, and the rotate feedback logic is not synthesized.
- Cycle timing is identical in both builds.

## Test plan
- SLL, `data_in`=0x00000001, `shift_src`=0, `shamt`=4 -> `result`=0x00000010, `done` in cycle 6, `sel_shift_src`=0.
- SRA, `data_in`=0x80000000, `shift_src`=1, `rs_amt`=0xFFFFFF23 (amount 3) -> `result`=0xF0000000, `done` in cycle 5, `sel_shift_src`=1.
- SRL, `data_in`=0xDEADBEEF, `shamt`=0 -> `result`=0xDEADBEEF, `done` in cycle 2. Second SRL with `shamt`=31 -> `result`=0x00000001, `done` in cycle 33.
- ROR, `data_in`=0x00000003, `shamt`=1:
  - with `SHIFT_ROTATE_EN` -> `result`=0x80000001.
  - without -> `result`=0x00000001.
- `start` held high across an SLL by 2 -> exactly one operation per IDLE visit. The pulse seen in cycle 4 starts no new op; the next op is accepted in cycle 5.
- `reset_n`=0 in cycle 3 of an SLL by 8 -> from the next cycle, state is IDLE and all outputs are 0; no `done` pulse appears afterwards.
